lfsr_checker: RTL and testbench
===============================

# lfsr_checker

Serial receive-side checker for the 6-bit Galois LFSR pattern generator. It consumes the generator's serial output (stage 5, one bit per valid cycle) and self-synchronises to the sequence by predicting each bit from the last six received bits. After synchronising it declares lock, then flags and counts bit errors. It sits at the far end of a link or loopback under test, paired with the LFSR pattern generator.

## Interface
- `LOCK_CNT`, default 12: consecutive matches required to declare lock.
- `LOSS_CNT`, default 3: consecutive mismatches in LOCKED that drop lock.
- `CNT_W`, default 16: width of the error counter.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `din` in 1: received serial bit.
- `din_valid` in 1: `din` is sampled only when this is high.
- `locked` out 1: high while in LOCKED.
- `err` out 1: one-cycle pulse when a mismatch is counted in LOCKED.
- `err_cnt` out CNT_W: number of LOCKED mismatches, saturating.

## Operation
- The generator's output stream obeys the recurrence y(n) = y(n-2) ^ y(n-5) ^ y(n-6).
- Starting from the generator's reset state 6'b111111, the stream is 1,1,0,0,1,0,1 and repeats with period 7.
- History register `hist[5:0]`: `hist[k]` holds y(n-1-k). On every valid bit, `din` shifts into `hist[0]` unconditionally, in every state. This is what makes the checker self-synchronising.
- Predicted bit: `exp` = `hist[1]` ^ `hist[4]` ^ `hist[5]`.
- Mismatch is (`din` != `exp`) OR degenerate history. Degenerate history means `hist` == 6'h00 or 6'h3F; neither occurs in a valid stream, so this blocks false lock on a stuck line.
- Counters:
  - `fill_cnt`: 0..6.
  - `match_cnt`: 0..`LOCK_CNT`.
  - `bad_cnt`: 0..`LOSS_CNT`.
  - `err_cnt`: CNT_W bits, saturates at all-ones and never wraps.
- FSM:
  - FILL: each valid bit increments `fill_cnt`; no comparison. Go to SEARCH when the 6th bit is accepted.
  - SEARCH: match increments `match_cnt`; mismatch clears it. When the match that makes `match_cnt` == `LOCK_CNT` is accepted, go to LOCKED, clear `match_cnt` and `bad_cnt`. No `err` and no `err_cnt` update in SEARCH.
  - LOCKED:
    - Mismatch: pulse `err`, increment `err_cnt` (saturating), increment `bad_cnt`.
    - Match: clear `bad_cnt`.
    - When `bad_cnt` reaches `LOSS_CNT`, go to SEARCH with `match_cnt` = 0. The history is not refilled.
- `err_cnt` is cumulative across lock losses; only reset clears it.
- `din_valid` low: all state holds, and `err` is 0 that cycle.

## Timing
- All outputs are registered. The response to a bit sampled at edge k is visible after edge k.
- Reset (`rst` low, asynchronous, at any time including mid-lock):
  - State = FILL.
  - `hist` = 0 and all counters = 0.
  - `locked` = 0, `err` = 0, `err_cnt` = 0.
- Reset release is synchronous to the next edge; the first valid bit after that edge is fill bit 1.
- Lock latency with a continuous error-free stream: `locked` rises after the (6 + `LOCK_CNT`)-th valid bit, i.e. the 18th with defaults.
- `err` is high exactly one cycle per counted mismatch. Back-to-back mismatches give back-to-back pulses.
- When the LOCKED→SEARCH transition happens on the `LOSS_CNT`-th mismatch, that bit still pulses `err` and counts; `locked` falls after the same edge.
- A single flipped bit in LOCKED produces exactly 4 mismatches: at the bit itself and at +2, +5 and +6 bits later. These are never 3 in a row, so lock is kept.

## Test plan
- Reset, then `din_valid` = 1 continuously with stream 1100101 repeating → `locked` = 0 through 17 bits, `locked` = 1 after the 18th; `err_cnt` stays 0 over 200 bits.
- Locked, flip one bit → exactly 4 `err` pulses, at offsets 0, 2, 5 and 6 bits; `err_cnt` = 4; `locked` stays 1; stream continues clean afterwards.
- Locked, force `din` = 1 constantly → `locked` falls within 9 valid bits and stays 0 for as long as `din` stays stuck. Repeat with `din` = 0: same result.
- Stream with `din_valid` toggling 1/0 every cycle → lock after 18 valid bits (36 cycles); `err` never asserts on an invalid cycle.
- `CNT_W` = 4, continuous random data in LOCKED, with lock re-forced via a preload of the clean stream → `err_cnt` saturates at 4'hF and never wraps.
- Assert `rst` low asynchronously mid-lock, between clock edges → `locked`, `err` and `err_cnt` go to 0 immediately. After release, relock takes 18 valid bits.

Source files
------------

// File: rtl/lfsr_checker.sv
// Receive-side checker for the 6-bit Galois LFSR pattern (period-7 serial stream).
// Self-synchronises from received history, declares lock, then flags and counts bit errors.
module lfsr_checker #(
  parameter int LOCK_CNT = 12,
  parameter int LOSS_CNT = 3,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din,
  input  logic             din_valid,
  output logic             locked,
  output logic             err,
  output logic [CNT_W-1:0] err_cnt,
  output logic [1:0]       dbg_state
);

  localparam int MW = (LOCK_CNT > 1) ? $clog2(LOCK_CNT + 1) : 1;
  localparam int BW = (LOSS_CNT > 1) ? $clog2(LOSS_CNT + 1) : 1;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    SEARCH = 2'd1,
    LOCKED = 2'd2
  } state_t;

  state_t        state;
  logic [5:0]    hist;
  logic [2:0]    fill_cnt;
  logic [MW-1:0] match_cnt;
  logic [BW-1:0] bad_cnt;
  logic          pred;
  logic          mismatch;

  // hist[k] holds the bit received k+1 valid cycles ago.
  assign pred     = hist[1] ^ hist[4] ^ hist[5];
  // An all-zero or all-one history never occurs in a real stream, so treat it
  // as a mismatch to keep a stuck line from ever locking.
  assign mismatch = (din != pred) || (hist == 6'h00) || (hist == 6'h3F);

  assign dbg_state = state;

  // din is a pure valid-qualified stream: a bit is consumed on every rising
  // edge where din_valid is high; there is no back-pressure.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= FILL;
      hist      <= 6'h00;
      fill_cnt  <= 3'd0;
      match_cnt <= '0;
      bad_cnt   <= '0;
      locked    <= 1'b0;
      err       <= 1'b0;
      err_cnt   <= '0;
    end else begin
      err <= 1'b0;
      if (din_valid) begin
        hist <= {hist[4:0], din};
        case (state)
          FILL: begin
            fill_cnt <= fill_cnt + 3'd1;
            if (fill_cnt == 3'd5) state <= SEARCH;
          end
          SEARCH: begin
            if (mismatch) begin
              match_cnt <= '0;
            end else if (match_cnt == MW'(LOCK_CNT - 1)) begin
              state     <= LOCKED;
              locked    <= 1'b1;
              match_cnt <= '0;
              bad_cnt   <= '0;
            end else begin
              match_cnt <= match_cnt + MW'(1);
            end
          end
          LOCKED: begin
            if (mismatch) begin
              err <= 1'b1;
              if (err_cnt != '1) err_cnt <= err_cnt + CNT_W'(1);
              if (bad_cnt == BW'(LOSS_CNT - 1)) begin
                state     <= SEARCH;
                locked    <= 1'b0;
                bad_cnt   <= '0;
                match_cnt <= '0;
              end else begin
                bad_cnt <= bad_cnt + BW'(1);
              end
            end else begin
              bad_cnt <= '0;
            end
          end
          default: state <= FILL;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lfsr_checker.sv
// Bench for lfsr_checker: two instances (default width and CNT_W=4) driven in
// parallel and compared every cycle against a stream-level reference model.
module tb_lfsr_checker;

  logic        clk;
  logic        rst;
  logic        din;
  logic        din_valid;
  logic        locked, err;
  logic [15:0] err_cnt;
  logic [1:0]  dbg_state;
  logic        locked4, err4;
  logic [3:0]  err_cnt4;
  logic [1:0]  dbg_state4;

  lfsr_checker u_dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .locked(locked), .err(err), .err_cnt(err_cnt), .dbg_state(dbg_state)
  );

  lfsr_checker #(.CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid),
    .locked(locked4), .err(err4), .err_cnt(err_cnt4), .dbg_state(dbg_state4)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit cmp_en   = 0;

  // ---------------- reference model ----------------
  // Works on the list of received bits: prediction comes from the recurrence
  // y(n) = y(n-2) ^ y(n-5) ^ y(n-6); lock/loss are run lengths of matches.
  bit hq[$];
  int m_phase;     // 0 filling, 1 searching, 2 locked
  int m_run;       // consecutive matches while searching
  int m_bad;       // consecutive mismatches while locked
  bit m_locked, m_err;
  int m_cnt16, m_cnt4;

  function automatic void model_reset();
    hq.delete();
    m_phase = 0; m_run = 0; m_bad = 0;
    m_locked = 0; m_err = 0; m_cnt16 = 0; m_cnt4 = 0;
  endfunction

  function automatic void model_bit(bit d);
    bit pred, mis;
    int ones;
    if (m_phase == 0) begin
      hq.push_back(d);
      if (hq.size() == 6) m_phase = 1;
      return;
    end
    ones = 0;
    foreach (hq[i]) ones += int'(hq[i]);
    pred = hq[4] ^ hq[1] ^ hq[0];
    mis  = (d != pred) || (ones == 0) || (ones == 6);
    if (m_phase == 1) begin
      m_run = mis ? 0 : m_run + 1;
      if (m_run == 12) begin
        m_phase = 2; m_locked = 1; m_run = 0; m_bad = 0;
      end
    end else if (mis) begin
      m_err = 1;
      if (m_cnt16 < 65535) m_cnt16++;
      if (m_cnt4 < 15) m_cnt4++;
      m_bad++;
      if (m_bad == 3) begin
        m_phase = 1; m_locked = 0; m_run = 0; m_bad = 0;
      end
    end else begin
      m_bad = 0;
    end
    hq.push_back(d);
    void'(hq.pop_front());
  endfunction

  // ---------------- compare process ----------------
  always @(negedge clk) begin
    if (cmp_en) begin
      checks++;
      if (locked !== m_locked || err !== m_err || err_cnt !== 16'(m_cnt16) || dbg_state === 2'd3) begin
        failures++;
        $display("FAIL cmp16 t=%0t locked=%b err=%b cnt=%0d state=%0d required locked=%b err=%b cnt=%0d",
                 $time, locked, err, err_cnt, dbg_state, m_locked, m_err, m_cnt16);
      end
      checks++;
      if (locked4 !== m_locked || err4 !== m_err || err_cnt4 !== 4'(m_cnt4) || dbg_state4 === 2'd3) begin
        failures++;
        $display("FAIL cmp4 t=%0t locked=%b err=%b cnt=%0d state=%0d required locked=%b err=%b cnt=%0d",
                 $time, locked4, err4, err_cnt4, dbg_state4, m_locked, m_err, m_cnt4);
      end
    end
  end

  // ---------------- driver tasks ----------------
  bit pat[7] = '{1, 1, 0, 0, 1, 0, 1};
  int sp = 0;

  function automatic bit clean();
    bit b;
    b  = pat[sp];
    sp = (sp + 1) % 7;
    return b;
  endfunction

  task automatic step(input bit v, input bit d);
    din       = d;
    din_valid = v;
    @(posedge clk);
    m_err = 0;
    if (rst && v) model_bit(d);
    #1;
  endtask

  task automatic check(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  // Asynchronous reset between edges, checked before the next edge.
  task automatic do_reset(input string name);
    #2 rst = 1'b0;
    model_reset();
    #1;
    check({name, "_locked"}, int'(locked), 0);
    check({name, "_err"}, int'(err), 0);
    check({name, "_cnt"}, int'(err_cnt), 0);
    check({name, "_cnt4"}, int'(err_cnt4), 0);
    step(1, 1'b1);
    step(0, 1'b0);
    rst = 1'b1;
  endtask

  task automatic relock(input string name);
    for (int i = 0; i < 100 && !locked; i++) step(1, clean());
    check(name, int'(locked), 1);
  endtask

  task automatic stuck(input bit level, input string name);
    int fell_at;
    bit relocked;
    fell_at  = 0;
    relocked = 0;
    for (int i = 1; i <= 30; i++) begin
      step(1, level);
      if (!locked && fell_at == 0) fell_at = i;
      if (locked && fell_at != 0) relocked = 1;
    end
    check({name, "_fell_by_9"}, int'(fell_at >= 1 && fell_at <= 9), 1);
    check({name, "_stays_down"}, int'(relocked), 0);
    relock({name, "_relock"});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int offs[$];
    int cyc;
    bit bad_flag, wrapped;
    int prev4;
    din = 0; din_valid = 0; rst = 1'b1;
    model_reset();
    #2 rst = 1'b0;
    step(0, 0); step(0, 0);
    rst    = 1'b1;
    cmp_en = 1;
    check("reset_locked", int'(locked), 0);
    check("reset_cnt", int'(err_cnt), 0);

    // clean stream: lock after bit 18, no errors over 200 bits
    for (int i = 1; i <= 200; i++) begin
      step(1, clean());
      if (i == 17) check("lock_bit17", int'(locked), 0);
      if (i == 18) check("lock_bit18", int'(locked), 1);
    end
    check("clean_cnt", int'(err_cnt), 0);

    // single flipped bit: errors at offsets 0,2,5,6, lock kept
    bad_flag = 0;
    step(1, ~clean());
    if (err) offs.push_back(0);
    for (int j = 1; j <= 20; j++) begin
      step(1, clean());
      if (err) offs.push_back(j);
      if (!locked) bad_flag = 1;
    end
    check("flip_npulses", offs.size(), 4);
    if (offs.size() == 4) begin
      check("flip_off0", offs[0], 0);
      check("flip_off1", offs[1], 2);
      check("flip_off2", offs[2], 5);
      check("flip_off3", offs[3], 6);
    end
    check("flip_cnt", int'(err_cnt), 4);
    check("flip_lock_kept", int'(bad_flag), 0);

    stuck(1'b1, "stuck1");
    stuck(1'b0, "stuck0");

    // din_valid toggling: 18 valid bits = 36 cycles
    do_reset("rst_a");
    bad_flag = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (cyc % 2 == 1) step(1, clean());
      else begin
        step(0, 1'($urandom_range(0, 1)));
        if (err) bad_flag = 1;
      end
      if (cyc == 34) check("toggle_cyc34", int'(locked), 0);
      if (cyc == 36) check("toggle_cyc36", int'(locked), 1);
    end
    check("toggle_err_invalid", int'(bad_flag), 0);

    // random data with re-forced lock: 4-bit counter saturates, never wraps
    wrapped = 0;
    prev4   = int'(err_cnt4);
    for (int r = 0; r < 12; r++) begin
      relock("sat_relock");
      for (int k = 0; k < 30; k++) begin
        step(1, 1'($urandom_range(0, 1)));
        if (int'(err_cnt4) < prev4) wrapped = 1;
        prev4 = int'(err_cnt4);
      end
    end
    check("sat_value", int'(err_cnt4), 15);
    check("sat_no_wrap", int'(wrapped), 0);

    // asynchronous reset mid-lock, then relock in 18 valid bits
    relock("pre_rst_lock");
    do_reset("rst_b");
    for (int i = 1; i <= 18; i++) begin
      step(1, clean());
      if (i == 17) check("relock_bit17", int'(locked), 0);
      if (i == 18) check("relock_bit18", int'(locked), 1);
    end
    step(0, 0);
    step(0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
